// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes (in1 - in2 - bin) mod 2^WIDTH
//   one bit per clock, LSB first. A start/busy/done handshake frames each
//   operation. Operand and borrow naming match the parallel adder, so the
//   two blocks can be dropped side by side into the arithmetic datapath.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to add the ovf port. ovf is
//   the two's-complement overflow flag of the subtraction.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only while idle
//   in1    in   WIDTH  minuend, captured with start
//   in2    in   WIDTH  subtrahend, captured with start
//   bin    in   1      borrow-in, captured with start
//   busy   out  1      high while an operation is in progress
//   done   out  1      single-cycle completion pulse
//   diff   out  WIDTH  result, updated only on completion
//   bout   out  1      borrow-out, high iff in1 < in2 + bin (unsigned)
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Holds the WIDTH-1 result bits produced so far. The final bit is
  // concatenated on the completion edge, so no WIDTH-th bit is ever stored.
  logic [WIDTH-2:0] r_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  logic [1:0]       step;
  logic             step_d;
  logic             step_br;
  logic             last_step;
  logic [WIDTH-1:0] r_cat;

  // One full-subtractor bit step: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b,
                                         input logic br);
    logic d;
    logic bo;
    d  = a ^ b ^ br;
    bo = (~a & b) | (~(a ^ b) & br);
    return {bo, d};
  endfunction

  assign step      = sub_bit(a_q[0], b_q[0], br_q);
  assign step_d    = step[0];
  assign step_br   = step[1];
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB; everything already collected moves down one.
  assign r_cat     = {step_d, r_q};
  assign busy      = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          a_q   <= in1;
          b_q   <= in2;
          br_q  <= bin;
          r_q   <= '0;
          cnt_q <= '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_q <= in1[WIDTH-1];
          b_msb_q <= in2[WIDTH-1];
`endif
        end
      end else begin
        a_q   <= {1'b0, a_q[WIDTH-1:1]};
        b_q   <= {1'b0, b_q[WIDTH-1:1]};
        br_q  <= step_br;
        r_q   <= r_cat[WIDTH-1:1];
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_step) begin
          diff <= r_cat;
          bout <= step_br;
          done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // Operands of differing sign and a result whose sign departs from
          // the minuend is the only way a signed subtraction can overflow.
          ovf  <= (a_msb_q != b_msb_q) && (step_d != a_msb_q);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1   = '0;
  logic [W-1:0] in2   = '0;
  logic         bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi);
    logic [W:0] t;
    exp_t       e;
    t   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d = t[W-1:0];
    e.b = t[W];
    e.o = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  // Drive a start for one edge; optionally record the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input bit push);
    in1   = a;
    in2   = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back(model(a, b, bi));
  endtask

  // Advance until done is seen (n = edges waited) or the budget runs out (n = -1).
  task automatic wait_done(input int budget, output int n, output int busy_low);
    n = -1;
    busy_low = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n = i;
        return;
      end
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    total_cnt++;
    if ({busy, done, diff, bout} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b diff=%0d bout=%b, want all 0",
               busy, done, diff, bout);
    else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
    else pass_cnt++;
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int   n;
    int   bl;
    exp_t e;
    issue(8'd10, 8'd5, 1'b0, 1'b1);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", busy);
    else pass_cnt++;
    wait_done(40, n, bl);
    total_cnt++;
    if (n !== 8) $display("FAIL basic_latency: got %0d edges want 8", n);
    else pass_cnt++;
    total_cnt++;
    if (bl !== 0) $display("FAIL basic_busy_hold: busy low %0d cycles want 0", bl);
    else pass_cnt++;
    e = sb.pop_front();
    total_cnt++;
    if (diff !== e.d || bout !== e.b)
      $display("FAIL basic_result: diff=%0d bout=%b want diff=%0d bout=%b",
               diff, bout, e.d, e.b);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_borrow();
    int   n;
    int   bl;
    exp_t e;
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic         cv[2];
    av[0] = 8'd5; bv[0] = 8'd10; cv[0] = 1'b0;
    av[1] = 8'd0; bv[1] = 8'd0;  cv[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(av[k], bv[k], cv[k], 1'b1);
      wait_done(40, n, bl);
      e = sb.pop_front();
      total_cnt++;
      if (n !== 8 || diff !== e.d || bout !== e.b)
        $display("FAIL borrow_%0d: n=%0d diff=%0d bout=%b want n=8 diff=%0d bout=%b",
                 k, n, diff, bout, e.d, e.b);
      else pass_cnt++;
    end
  endtask

  task automatic test_ovf();
    int   n;
    int   bl;
    exp_t e;
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic         cv[2];
    av[0] = 8'd128; bv[0] = 8'd1;  cv[0] = 1'b0;
    av[1] = 8'd100; bv[1] = 8'd50; cv[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(av[k], bv[k], cv[k], 1'b1);
      wait_done(40, n, bl);
      e = sb.pop_front();
      total_cnt++;
      if (n !== 8 || diff !== e.d || bout !== e.b)
        $display("FAIL ovf_case_%0d: n=%0d diff=%0d bout=%b want n=8 diff=%0d bout=%b",
                 k, n, diff, bout, e.d, e.b);
      else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
      total_cnt++;
      if (ovf !== e.o) $display("FAIL ovf_flag_%0d: got %b want %b", k, ovf, e.o);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   bl;
    exp_t e;
    issue(8'd200, 8'd100, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Busy cycle 3: this request and the operand changes must be ignored.
    in1   = 8'd1;
    in2   = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, n, bl);
    e = sb.pop_front();
    total_cnt++;
    if (n !== 5) $display("FAIL ignore_latency: got %0d edges want 5", n);
    else pass_cnt++;
    total_cnt++;
    if (diff !== e.d || bout !== e.b)
      $display("FAIL ignore_result: diff=%0d bout=%b want diff=%0d bout=%b",
               diff, bout, e.d, e.b);
    else pass_cnt++;
    // Request on the done cycle, held high for a few extra edges.
    in1   = 8'd50;
    in2   = 8'd20;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(8'd50, 8'd20, 1'b0));
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, n, bl);
    e = sb.pop_front();
    total_cnt++;
    if (n !== 6 || bl !== 0)
      $display("FAIL b2b_latency: got %0d edges (busy low %0d) want 6 (0)", n, bl);
    else pass_cnt++;
    total_cnt++;
    if (diff !== e.d || bout !== e.b)
      $display("FAIL b2b_result: diff=%0d bout=%b want diff=%0d bout=%b",
               diff, bout, e.d, e.b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   n;
    int   bl;
    int   extra;
    exp_t e;
    issue(8'd255, 8'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, diff, bout} !== '0)
      $display("FAIL midreset_outputs: busy=%b done=%b diff=%0d bout=%b, want all 0",
               busy, done, diff, bout);
    else pass_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL midreset_no_done: %0d active cycles want 0", extra);
    else pass_cnt++;
    issue(8'd255, 8'd1, 1'b0, 1'b1);
    wait_done(40, n, bl);
    e = sb.pop_front();
    total_cnt++;
    if (n !== 8 || diff !== e.d || bout !== e.b)
      $display("FAIL midreset_fresh: n=%0d diff=%0d bout=%b want n=8 diff=%0d bout=%b",
               n, diff, bout, e.d, e.b);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int   n;
    int   bl;
    exp_t e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    for (int k = 0; k < 8; k++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      issue(a, b, c, 1'b1);
      wait_done(40, n, bl);
      e = sb.pop_front();
      total_cnt++;
      if (n !== 8 || diff !== e.d || bout !== e.b)
        $display("FAIL random_%0d: %0d-%0d-%0d n=%0d diff=%0d bout=%b want diff=%0d bout=%b",
                 k, a, b, c, n, diff, bout, e.d, e.b);
      else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
      total_cnt++;
      if (ovf !== e.o) $display("FAIL random_ovf_%0d: got %b want %b", k, ovf, e.o);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    total_cnt++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
